tpx3_multi_pulse_gen: RTL and testbench
=======================================

Name: tpx3_multi_pulse_gen

Overview:
- Parametrised successor to the single-chip Shutter/ExtTPulse drive path.
- Generates a programmable, repeatable pulse train (shutter or test pulse) for CHANNELS Timepix3 chips from one trigger.
- Each channel has its own enable, polarity and cycle-accurate skew delay. One T0_SYNC strobe is common to all channels.
- Sits between the register-file configuration and the per-chip output pins inside the multi-chip readout core.

Parameters:
CHANNELS, 4, number of chip outputs (1..16)
CNT_WIDTH, 32, width of delay/width/period counters
REPEAT_WIDTH, 16, width of repeat and pulse counters
SKEW_WIDTH, 4, per-channel skew field width; max skew 2^SKEW_WIDTH-1 cycles

Ports:
BUS_CLK  input  1  block clock; all logic on rising edge
BUS_RST  input  1  asynchronous active-high reset
START  input  1  single-cycle start strobe
STOP  input  1  single-cycle abort strobe
CONF_DELAY  input  CNT_WIDTH  cycles from T0_SYNC to first pulse
CONF_WIDTH  input  CNT_WIDTH  pulse high time in cycles
CONF_PERIOD  input  CNT_WIDTH  pulse start-to-start period in cycles
CONF_REPEAT  input  REPEAT_WIDTH  pulse count; 0 = run until STOP
CONF_EN  input  CHANNELS  per-channel enable
CONF_INVERT  input  CHANNELS  per-channel output polarity
CONF_SKEW  input  CHANNELS*SKEW_WIDTH  per-channel delay; channel i uses bits [i*SKEW_WIDTH +: SKEW_WIDTH]
PULSE  output  CHANNELS  per-chip pulse outputs, registered
T0_SYNC  output  1  one-cycle strobe marking sequence start
BUSY  output  1  high from START acceptance until return to IDLE
DONE  output  1  sticky; set on normal completion, cleared by next accepted START
PULSE_CNT  output  REPEAT_WIDTH  completed base pulses; wraps in infinite mode

Behaviour:
- Reset (async, BUS_RST=1): all outputs 0, latched config 0, skew lines cleared, state IDLE.
- Configuration is latched only on an accepted START. Inputs may change freely while BUSY.
- States: IDLE, DELAY, HIGH, LOW, FLUSH.
- IDLE:
  - START accepted at edge k (BUSY=0, STOP=0): latch config, clear PULSE_CNT and DONE.
  - T0_SYNC=1 during cycle k+1 only; BUSY=1 from cycle k+1.
  - Next state is DELAY; if CONF_DELAY=0, next state is HIGH.
- DELAY: count CONF_DELAY cycles. The base pulse first goes high in cycle k+1+CONF_DELAY.
- HIGH:
  - Base pulse high for max(CONF_WIDTH,1) cycles, then LOW.
  - CONF_WIDTH=0 is treated as 1.
- LOW:
  - Base pulse low for the remaining time so start-to-start equals effective period Peff = max(CONF_PERIOD, Weff+1).
  - The PULSE_CNT increment occurs at the end of each LOW phase.
  - If CONF_REPEAT≠0 and PULSE_CNT reaches CONF_REPEAT, go to FLUSH; otherwise go to HIGH.
- FLUSH: wait 2^SKEW_WIDTH cycles so delayed edges drain, then IDLE, BUSY=0, DONE=1.
- Channel output:
  - PULSE[i] = (EN_i ? base delayed by SKEW_i cycles : 0) XOR INVERT_i, using latched values, registered.
  - Implemented as per-channel shift line of depth 2^SKEW_WIDTH-1.
  - Skew 0 follows base with no extra delay.
  - Inverted channels idle high after the first accepted START.
- STOP:
  - From any non-IDLE state: next cycle base=0, skew lines cleared, state IDLE, BUSY=0.
  - DONE stays 0; PULSE_CNT holds its value.
  - STOP in IDLE has no effect.
- Simultaneous events:
  - START while BUSY is ignored.
  - START and STOP in the same cycle: STOP wins, START ignored.
- Infinite mode: PULSE_CNT wraps from 2^REPEAT_WIDTH-1 to 0; the sequence continues.
- Reset mid-sequence: immediate return to reset values; no partial pulse persists after the reset edge.

Test Plan:
- Single pulse: DELAY=3, WIDTH=2, PERIOD=5, REPEAT=1, EN=4'b0001, SKEW=0; START at edge 10 -> T0_SYNC in cycle 11; PULSE[0] high cycles 14–15; DONE=1 and BUSY=0 after FLUSH (16 cycles); PULSE_CNT=1.
- Skew: REPEAT=3, EN=4'b1111, SKEWs 0,1,5,15 -> channel i rising edges offset by exactly its skew from channel 0 for all three pulses; PULSE_CNT=3; all channels low at DONE.
- Degenerate timing: WIDTH=0, PERIOD=0 -> high 1 cycle, period 2; WIDTH=4, PERIOD=3 -> period 5. Inverted channel stays low during pulses and idles high.
- Abort and overlap: REPEAT=0; STOP after 7 pulses -> next cycle PULSE=INVERT, BUSY=0, DONE=0, PULSE_CNT=7. START while BUSY is ignored; START+STOP in the same cycle is ignored.
- Wrap: REPEAT_WIDTH=4, REPEAT=0, run 20 pulses -> PULSE_CNT reads 4.
- Reset: assert BUS_RST asynchronously mid-HIGH -> PULSE, BUSY, T0_SYNC, DONE all 0 before the next clock edge.

Source files
------------

// File: rtl/tpx3_multi_pulse_gen.sv
// Purpose : programmable repeatable pulse train (shutter / test pulse) fanned out to CHANNELS chips,
//           each with its own enable, polarity and cycle-accurate skew; one shared T0_SYNC strobe.
// Latency : T0_SYNC and BUSY one cycle after the START edge; base pulse CONF_DELAY cycles after T0_SYNC;
//           PULSE[i] follows base by skew_i cycles.
// Backpressure: none; START is ignored while BUSY, STOP aborts on the next edge and wins over START.
// Ports   : BUS_CLK/BUS_RST clock and async active-high reset; START/STOP strobes;
//           CONF_* configuration, latched only on an accepted START;
//           PULSE per-chip outputs; T0_SYNC sequence start strobe; BUSY sequence active;
//           DONE sticky normal completion; PULSE_CNT completed base pulses.
module tpx3_multi_pulse_gen #(
    parameter int CHANNELS     = 4,
    parameter int CNT_WIDTH    = 32,
    parameter int REPEAT_WIDTH = 16,
    parameter int SKEW_WIDTH   = 4
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic                           START,
    input  logic                           STOP,
    input  logic [CNT_WIDTH-1:0]           CONF_DELAY,
    input  logic [CNT_WIDTH-1:0]           CONF_WIDTH,
    input  logic [CNT_WIDTH-1:0]           CONF_PERIOD,
    input  logic [REPEAT_WIDTH-1:0]        CONF_REPEAT,
    input  logic [CHANNELS-1:0]            CONF_EN,
    input  logic [CHANNELS-1:0]            CONF_INVERT,
    input  logic [CHANNELS*SKEW_WIDTH-1:0] CONF_SKEW,
    output logic [CHANNELS-1:0]            PULSE,
    output logic                           T0_SYNC,
    output logic                           BUSY,
    output logic                           DONE,
    output logic [REPEAT_WIDTH-1:0]        PULSE_CNT
);

    localparam int DEPTH = (1 << SKEW_WIDTH) - 1;
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_M1 = CNT_WIDTH'(DEPTH);

    typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, FLUSH} state_t;

    state_t                        state;
    logic [CNT_WIDTH-1:0]          cnt;
    logic [CNT_WIDTH-1:0]          high_m1;
    logic [CNT_WIDTH-1:0]          low_m1;
    logic [REPEAT_WIDTH-1:0]       rep_l;
    logic [CHANNELS-1:0]           en_l;
    logic [CHANNELS-1:0]           inv_l;
    logic [CHANNELS*SKEW_WIDTH-1:0] skew_l;
    logic [DEPTH-1:0]              dly_q;

    logic                          start_acc;
    logic                          stop_acc;
    logic                          base_nxt;
    logic                          last_pulse;
    logic [REPEAT_WIDTH-1:0]       cnt_inc;
    logic [CNT_WIDTH-1:0]          w_eff_in;
    logic [CNT_WIDTH-1:0]          high_m1_in;
    logic [CNT_WIDTH-1:0]          low_m1_in;
    logic [CHANNELS-1:0]           eff_en;
    logic [CHANNELS-1:0]           eff_inv;
    logic [CHANNELS*SKEW_WIDTH-1:0] eff_skew;
    logic [DEPTH:0]                line;
    logic [CHANNELS-1:0]           tap;

    assign start_acc  = START && !STOP && (state == IDLE);
    assign stop_acc   = STOP && (state != IDLE);
    assign cnt_inc    = PULSE_CNT + 1'b1;
    assign last_pulse = (rep_l != '0) && (cnt_inc == rep_l);

    // Phase lengths minus one. Width 0 behaves as 1; the low phase is at least
    // one cycle, so period is stretched to width+1 when it is too short.
    assign w_eff_in   = (CONF_WIDTH == '0) ? ONE : CONF_WIDTH;
    assign high_m1_in = w_eff_in - ONE;
    assign low_m1_in  = (CONF_PERIOD > w_eff_in) ? (CONF_PERIOD - w_eff_in - ONE) : '0;

    // On the START edge the channel logic must already use the new config.
    assign eff_en   = start_acc ? CONF_EN     : en_l;
    assign eff_inv  = start_acc ? CONF_INVERT : inv_l;
    assign eff_skew = start_acc ? CONF_SKEW   : skew_l;

    // Base level for the coming cycle; lets a zero-skew channel register the
    // base pulse in the same cycle the FSM enters HIGH.
    always_comb begin
        base_nxt = 1'b0;
        if (start_acc) begin
            base_nxt = (CONF_DELAY == '0);
        end else if (!STOP) begin
            case (state)
                DELAY:   base_nxt = (cnt == '0);
                HIGH:    base_nxt = (cnt != '0);
                LOW:     base_nxt = (cnt == '0) && !last_pulse;
                default: base_nxt = 1'b0;
            endcase
        end
    end

    // line[s] is the base level s cycles before the coming cycle.
    assign line = {dly_q, base_nxt};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_tap
        logic [SKEW_WIDTH-1:0] sk;
        assign sk     = eff_skew[g*SKEW_WIDTH +: SKEW_WIDTH];
        assign tap[g] = line[sk];
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state     <= IDLE;
            cnt       <= '0;
            high_m1   <= '0;
            low_m1    <= '0;
            rep_l     <= '0;
            en_l      <= '0;
            inv_l     <= '0;
            skew_l    <= '0;
            T0_SYNC   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PULSE_CNT <= '0;
        end else begin
            T0_SYNC <= start_acc;
            if (start_acc) begin
                high_m1   <= high_m1_in;
                low_m1    <= low_m1_in;
                rep_l     <= CONF_REPEAT;
                en_l      <= CONF_EN;
                inv_l     <= CONF_INVERT;
                skew_l    <= CONF_SKEW;
                PULSE_CNT <= '0;
                DONE      <= 1'b0;
                BUSY      <= 1'b1;
                if (CONF_DELAY == '0) begin
                    state <= HIGH;
                    cnt   <= high_m1_in;
                end else begin
                    state <= DELAY;
                    cnt   <= CONF_DELAY - 1'b1;
                end
            end else if (stop_acc) begin
                state <= IDLE;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    DELAY: begin
                        if (cnt == '0) begin
                            state <= HIGH;
                            cnt   <= high_m1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt == '0) begin
                            state <= LOW;
                            cnt   <= low_m1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt == '0) begin
                            PULSE_CNT <= cnt_inc;
                            if (last_pulse) begin
                                state <= FLUSH;
                                cnt   <= FLUSH_M1;
                            end else begin
                                state <= HIGH;
                                cnt   <= high_m1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Channel outputs and skew lines; an abort drops every channel to its idle level at once.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            PULSE <= '0;
            dly_q <= '0;
        end else if (stop_acc) begin
            PULSE <= inv_l;
            dly_q <= '0;
        end else begin
            PULSE    <= (eff_en & tap) ^ eff_inv;
            dly_q[0] <= base_nxt;
            for (int j = 1; j < DEPTH; j++) begin
                dly_q[j] <= dly_q[j-1];
            end
        end
    end

endmodule

// File: tb/tb_tpx3_multi_pulse_gen.sv
// Purpose : self-checking bench for tpx3_multi_pulse_gen (4 channels, 8-bit timing, 4-bit repeat counter).
// Latency : outputs compared every cycle, 1 time unit after the rising edge.
// Backpressure: n/a; START noise is injected while the block is busy.
module tb_tpx3_multi_pulse_gen;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int RW = 4;
    localparam int SW = 4;

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST = 1'b1;
    logic              START = 1'b0;
    logic              STOP = 1'b0;
    logic [CW-1:0]     CONF_DELAY = '0;
    logic [CW-1:0]     CONF_WIDTH = '0;
    logic [CW-1:0]     CONF_PERIOD = '0;
    logic [RW-1:0]     CONF_REPEAT = '0;
    logic [CH-1:0]     CONF_EN = '0;
    logic [CH-1:0]     CONF_INVERT = '0;
    logic [CH*SW-1:0]  CONF_SKEW = '0;
    logic [CH-1:0]     PULSE;
    logic              T0_SYNC;
    logic              BUSY;
    logic              DONE;
    logic [RW-1:0]     PULSE_CNT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_rise;

    // Reference model state for the sequence in flight.
    int m_k, m_t0, m_weff, m_peff, m_rep, m_s, m_idle;
    logic [CH-1:0]    m_en, m_inv;
    logic [CH*SW-1:0] m_sk;

    tpx3_multi_pulse_gen #(
        .CHANNELS(CH), .CNT_WIDTH(CW), .REPEAT_WIDTH(RW), .SKEW_WIDTH(SW)
    ) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .START(START), .STOP(STOP),
        .CONF_DELAY(CONF_DELAY), .CONF_WIDTH(CONF_WIDTH), .CONF_PERIOD(CONF_PERIOD),
        .CONF_REPEAT(CONF_REPEAT), .CONF_EN(CONF_EN), .CONF_INVERT(CONF_INVERT),
        .CONF_SKEW(CONF_SKEW), .PULSE(PULSE), .T0_SYNC(T0_SYNC), .BUSY(BUSY),
        .DONE(DONE), .PULSE_CNT(PULSE_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Base pulse level in cycle c: pulses start at t0 and repeat every Peff cycles.
    function automatic int base_at(int c);
        int rel;
        rel = c - m_t0;
        if (rel < 0) return 0;
        if (m_rep != 0 && rel >= m_rep * m_peff) return 0;
        return ((rel % m_peff) < m_weff) ? 1 : 0;
    endfunction

    function automatic int cnt_at(int c);
        int cc;
        int n;
        cc = (c > m_s) ? m_s : c;
        n = (cc < m_t0) ? 0 : (cc - m_t0) / m_peff;
        if (m_rep != 0 && n > m_rep) n = m_rep;
        return n % (1 << RW);
    endfunction

    // Expected {PULSE, T0_SYNC, BUSY, DONE, PULSE_CNT} in cycle c.
    function automatic logic [12:0] exp_at(int c);
        logic [CH-1:0] p;
        logic t0, b, d;
        for (int i = 0; i < CH; i++) begin
            int sk;
            sk = int'(m_sk[i*SW +: SW]);
            if (c > m_s) p[i] = m_inv[i];
            else         p[i] = (m_en[i] && (base_at(c - sk) == 1)) ^ m_inv[i];
        end
        t0 = (c == m_k + 1);
        b  = (c <= m_s) && (c >= m_k + 1) && (c < m_idle);
        d  = (c <= m_s) && (c >= m_idle);
        return {p, t0, b, d, RW'(cnt_at(c))};
    endfunction

    // Launch a sequence in the current cycle and compare every cycle against the model.
    task automatic run_seq(input int dly, input int wid, input int per, input int rep,
                           input logic [CH-1:0] en, input logic [CH-1:0] inv,
                           input logic [CH*SW-1:0] sk, input int stop_rel, input bit noise);
        int end_c;
        m_k    = cyc;
        m_weff = (wid == 0) ? 1 : wid;
        m_peff = (per > m_weff) ? per : m_weff + 1;
        m_t0   = m_k + 1 + dly;
        m_rep  = rep;
        m_en   = en;
        m_inv  = inv;
        m_sk   = sk;
        m_idle = (rep == 0) ? (1 << 30) : m_t0 + rep * m_peff + 16;
        m_s    = (stop_rel > 0) ? m_k + stop_rel : (1 << 30);
        end_c  = (stop_rel > 0) ? m_s + 3 : m_idle + 2;
        if (end_c > m_k + 2000) end_c = m_k + 2000;
        CONF_DELAY  = CW'(dly);
        CONF_WIDTH  = CW'(wid);
        CONF_PERIOD = CW'(per);
        CONF_REPEAT = RW'(rep);
        CONF_EN     = en;
        CONF_INVERT = inv;
        CONF_SKEW   = sk;
        START       = 1'b1;
        STOP        = 1'b0;
        first_rise  = -1;
        tick();
        while (cyc <= end_c) begin
            check($sformatf("run@%0d rel cycle %0d outputs", m_k, cyc - m_k),
                  {19'd0, PULSE, T0_SYNC, BUSY, DONE, PULSE_CNT}, {19'd0, exp_at(cyc)});
            if (first_rise < 0 && (PULSE[0] ^ inv[0])) first_rise = cyc - m_k;
            START = 1'b0;
            STOP  = (cyc == m_s);
            if (noise && cyc < m_s && cyc < m_idle) begin
                CONF_DELAY  = CW'($urandom);
                CONF_WIDTH  = CW'($urandom);
                CONF_PERIOD = CW'($urandom);
                CONF_REPEAT = RW'($urandom);
                CONF_EN     = CH'($urandom);
                CONF_INVERT = CH'($urandom);
                CONF_SKEW   = (CH*SW)'($urandom);
                START       = ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        START = 1'b0;
        STOP  = 1'b0;
    endtask

    typedef struct {
        int            dly, wid, per, rep;
        logic [CH-1:0] en, inv;
        logic [15:0]   sk;
        int            stop_rel;
        int            exp_cnt;
        logic          exp_done;
        logic [CH-1:0] exp_pulse;
        int            exp_rise;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // dly wid per rep en inv skew stop | cnt done pulse first-rise
        tbl[0] = '{3, 2, 5, 1, 4'b0001, 4'b0000, 16'h0000,  0, 1, 1'b1, 4'b0000, 4};
        tbl[1] = '{2, 2, 4, 3, 4'b1111, 4'b0000, 16'hF510,  0, 3, 1'b1, 4'b0000, 3};
        tbl[2] = '{0, 0, 0, 4, 4'b0011, 4'b0010, 16'h0000,  0, 4, 1'b1, 4'b0010, 1};
        tbl[3] = '{1, 4, 3, 2, 4'b0001, 4'b0000, 16'h0000,  0, 2, 1'b1, 4'b0000, 2};
        tbl[4] = '{1, 1, 3, 0, 4'b1111, 4'b1000, 16'h3210, 23, 7, 1'b0, 4'b1000, 2};
        tbl[5] = '{0, 1, 2, 0, 4'b0001, 4'b0000, 16'h0000, 41, 4, 1'b0, 4'b0000, 1};

        repeat (3) tick();
        check("reset outputs", {19'd0, PULSE, T0_SYNC, BUSY, DONE, PULSE_CNT}, 32'd0);
        BUS_RST = 1'b0;
        repeat (3) tick();
        check("idle after reset", {19'd0, PULSE, T0_SYNC, BUSY, DONE, PULSE_CNT}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_seq(tbl[v].dly, tbl[v].wid, tbl[v].per, tbl[v].rep, tbl[v].en, tbl[v].inv,
                    tbl[v].sk, tbl[v].stop_rel, 1'b1);
            check($sformatf("vec%0d PULSE_CNT", v), 32'(PULSE_CNT), 32'(tbl[v].exp_cnt));
            check($sformatf("vec%0d DONE", v), 32'(DONE), 32'(tbl[v].exp_done));
            check($sformatf("vec%0d BUSY", v), 32'(BUSY), 32'd0);
            check($sformatf("vec%0d PULSE", v), 32'(PULSE), 32'(tbl[v].exp_pulse));
            check($sformatf("vec%0d first rise", v), 32'(first_rise), 32'(tbl[v].exp_rise));
            repeat (2) tick();
        end

        // Randomised sequences against the model.
        for (int r = 0; r < 10; r++) begin
            int dly, wid, per, rep, weff, peff, stop_rel;
            dly  = $urandom_range(0, 4);
            wid  = $urandom_range(0, 4);
            per  = $urandom_range(0, 7);
            rep  = $urandom_range(1, 4);
            weff = (wid == 0) ? 1 : wid;
            peff = (per > weff) ? per : weff + 1;
            stop_rel = 0;
            if ($urandom_range(0, 2) == 0) stop_rel = $urandom_range(1, dly + rep * peff + 16);
            run_seq(dly, wid, per, rep, CH'($urandom), CH'($urandom), (CH*SW)'($urandom),
                    stop_rel, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        // START and STOP together in IDLE: nothing starts, DONE and count hold.
        run_seq(3, 2, 5, 1, 4'b0001, 4'b0000, 16'h0000, 0, 1'b0);
        START = 1'b1;
        STOP  = 1'b1;
        tick();
        START = 1'b0;
        STOP  = 1'b0;
        check("start+stop T0_SYNC", 32'(T0_SYNC), 32'd0);
        check("start+stop BUSY", 32'(BUSY), 32'd0);
        check("start+stop DONE", 32'(DONE), 32'd1);
        check("start+stop PULSE_CNT", 32'(PULSE_CNT), 32'd1);
        tick();
        check("start+stop BUSY later", 32'(BUSY), 32'd0);

        // Asynchronous reset in the middle of a HIGH phase.
        CONF_DELAY  = 8'd2;
        CONF_WIDTH  = 8'd5;
        CONF_PERIOD = 8'd8;
        CONF_REPEAT = '0;
        CONF_EN     = 4'b1111;
        CONF_INVERT = 4'b0100;
        CONF_SKEW   = '0;
        START       = 1'b1;
        tick();
        START = 1'b0;
        for (int w = 0; w < 20 && !PULSE[0]; w++) tick();
        check("reset test pulse reached HIGH", 32'(PULSE[0]), 32'd1);
        #2;
        BUS_RST = 1'b1;
        #1;
        check("async reset outputs", {19'd0, PULSE, T0_SYNC, BUSY, DONE, PULSE_CNT}, 32'd0);
        tick();
        BUS_RST = 1'b0;
        repeat (2) tick();
        check("after reset release", {19'd0, PULSE, T0_SYNC, BUSY, DONE, PULSE_CNT}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
